// File: rtl/regfile_dump_pkg.sv
// Shared types, sizes and checksum helper for the
// register file dump sequencer.
package regfile_dump_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  function automatic logic [DATA_W-1:0] csum_next(
    input logic [DATA_W-1:0] cur,
    input logic [DATA_W-1:0] data
  );
    return {cur[DATA_W-2:0], cur[DATA_W-1]} ^ data;
  endfunction

endpackage

// File: rtl/dump_csum.sv
// Rotate-xor checksum accumulator with clear
// and update enable.
module dump_csum
  import regfile_dump_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] value_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_o <= '0;
    end else if (clr_i) begin
      value_o <= '0;
    end else if (en_i) begin
      value_o <= csum_next(value_o, data_i);
    end
  end

endmodule

// File: rtl/regfile_dump.sv
// Walks a wrapping register range through the debug
// read port and streams it out with a running checksum.
module regfile_dump
  import regfile_dump_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] first_addr_i,
  input  logic [ADDR_W-1:0] last_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_reg_en_o,
  output logic [ADDR_W-1:0] rd_reg_addr_o,
  input  logic [DATA_W-1:0] rd_reg_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              out_last_o,
  output logic [DATA_W-1:0] checksum_o
);

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   rem_q;
  logic [ADDR_W-1:0] span;
  logic              load;
  logic              hs;
  logic              start_ok;
  logic              final_rd;

  assign span     = last_addr_i - first_addr_i;
  assign load     = (state_q == RUN)
                  & (~out_valid_o | out_ready_i);
  assign hs       = out_valid_o & out_ready_i;
  assign start_ok = (state_q == IDLE)
                  & start_i & ~abort_i;
  assign final_rd = (rem_q == (ADDR_W+1)'(1));

  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign rd_reg_en_o   = load;
  assign rd_reg_addr_o = load ? ptr_q : '0;

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  if (start_i) state_d = RUN;
        RUN:   if (load && final_rd) state_d = DRAIN;
        DRAIN: if (hs && out_last_o) state_d = DONE;
        DONE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
      out_data_o  <= '0;
      out_addr_o  <= '0;
    end else begin
      state_q <= state_d;
      if (abort_i) begin
        out_valid_o <= 1'b0;
        out_last_o  <= 1'b0;
      end else if (start_ok) begin
        ptr_q <= first_addr_i;
        rem_q <= {1'b0, span} + (ADDR_W+1)'(1);
      end else if (load) begin
        out_data_o  <= rd_reg_data_i;
        out_addr_o  <= ptr_q;
        out_valid_o <= 1'b1;
        out_last_o  <= final_rd;
        ptr_q       <= ptr_q + ADDR_W'(1);
        rem_q       <= rem_q - (ADDR_W+1)'(1);
      end else if (hs) begin
        out_valid_o <= 1'b0;
        out_last_o  <= 1'b0;
      end
    end
  end

  // an aborted beat must not reach the checksum
  dump_csum u_csum (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (start_ok),
    .en_i    (hs & ~abort_i),
    .data_i  (out_data_o),
    .value_o (checksum_o)
  );

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Sequencer that walks a contiguous, optionally wrapping range of architectural registers through the register file's debug read port (rd_reg_en / rd_reg_addr / rd_reg_data).
- Streams each value out on a valid/ready interface and maintains a running checksum.
- Sits directly downstream of the register file's debug read port. Feeds the secure-debug / attestation path: register snapshot on halt, or integrity check.

Parameters:
- NUM_REGS, 32, number of architectural registers (power of two)
- ADDR_W, 5, register index width, equal to log2(NUM_REGS)
- DATA_W, 32, register data width

Ports:
- clk_i  in  1  clock (single domain)
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  begin dump; sampled only in IDLE
- abort_i  in  1  cancel dump in progress
- first_addr_i  in  ADDR_W  first register index; sampled with start_i
- last_addr_i  in  ADDR_W  last register index; sampled with start_i
- busy_o  out  1  dump in progress
- done_o  out  1  one-cycle pulse on normal completion
- rd_reg_en_o  out  1  read enable to register file debug port
- rd_reg_addr_o  out  ADDR_W  read address to register file debug port
- rd_reg_data_i  in  DATA_W  combinational read data from register file
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  downstream accepts beat
- out_data_o  out  DATA_W  register value
- out_addr_o  out  ADDR_W  index of register in out_data_o
- out_last_o  out  1  final beat of the dump
- checksum_o  out  DATA_W  running checksum; final value valid from done_o until next start

Behaviour:
- Reset: every output is 0; state IDLE; internal pointer and remaining count are 0.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN: start_i=1.
  - RUN -> DRAIN: last read captured.
  - DRAIN -> DONE: handshake on the out_last_o beat.
  - DONE -> IDLE: unconditional, after one cycle.
  - any state -> IDLE: abort_i=1.
- Range and count:
  - count = ((last_addr_i - first_addr_i) mod NUM_REGS) + 1.
  - first==last gives 1 beat; first>last wraps through NUM_REGS-1 to 0.
  - first=0, last=31 dumps all 32 registers; r0 reads as 0.
  - Pointer increments modulo NUM_REGS.
- Start: start_i in IDLE at edge N latches the range and clears the checksum. busy_o is high from cycle N+1 through the DONE cycle inclusive. start_i is ignored whenever not in IDLE.
- Load condition: load = (state==RUN) & (!out_valid_o | out_ready_i).
  - rd_reg_en_o = load; rd_reg_addr_o = pointer when load, else 0.
  - The enable is never asserted speculatively, so the debug port is idle during stalls.
  - At the edge with load=1: capture rd_reg_data_i into out_data_o, pointer into out_addr_o, set out_valid_o, set out_last_o if this is the final read, advance the pointer, decrement the remaining count.
- Latency and throughput: first out_valid_o is in cycle N+2. With out_ready_i held high, one beat per cycle.
- Handshake:
  - A beat transfers when out_valid_o & out_ready_i.
  - out_data_o, out_addr_o and out_last_o hold stable while valid and not ready.
  - out_valid_o clears after a handshake unless a new load occurs at the same edge.
- Checksum: on each handshake, checksum = rotl1(checksum) ^ out_data_o, DATA_W-bit wrap.
- Completion: DONE is entered the cycle after the last handshake; done_o=1 in DONE only; checksum_o holds until the next accepted start.
- Abort: IDLE at the next edge.
  - out_valid_o, out_last_o and busy_o go to 0; done_o does not pulse.
  - checksum_o holds its partial value.
  - abort_i has priority over start_i and over a same-cycle handshake; that beat is not counted.
- Reset mid-dump: same as abort, except every output returns to 0.
- Coherency with register file writes: the register file writes on the falling edge. A captured value reflects every write committed before the capturing rising edge; no snapshot atomicity is provided.

Decomposition:
- Package regfile_dump_pkg holds: the state enum (IDLE, RUN, DRAIN, DONE), NUM_REGS, ADDR_W, DATA_W, and the rotate-xor checksum function.
- One sub-module, dump_csum: checksum accumulator with clear, update enable and value.

Test Plan:
- Preload r1=0x11111111, r2=0x22222222, r3=0x33333333; start first=1 last=3, ready high -> beats (1,0x11111111), (2,0x22222222), (3,0x33333333,last); checksums after each beat 0x11111111, 0x00000000, 0x33333333; done_o pulses once.
- first=0 last=0 -> single beat addr 0, data 0, out_last_o=1, checksum 0x00000000.
- first=30 last=1 with r30=0xA, r31=0xB, r1=0xC -> addresses 30, 31, 0, 1 in order; 4 beats; out_last_o on addr 1.
- Ready low 3 cycles after first valid -> out_data_o/out_addr_o stable, rd_reg_en_o=0 during stall; full sequence completes with no loss or duplication.
- Abort during beat 2 of a 32-register dump -> busy_o=0 and out_valid_o=0 next cycle, no done_o; start_i pulsed mid-dump beforehand is ignored.
- rst_i asserted mid-dump -> all outputs 0 next cycle; fresh start_i with first=5 last=6 completes normally.
